// File: rtl/uart_packet_rx.sv
// uart_packet_rx
// Receives 8N1 UART bytes and frames them into fixed-length packets:
//   STX, PAYLOAD_BYTES payload bytes, ETX.
// A bit FSM recovers bytes from the synchronised serial line. A packet FSM
// assembles the payload in a shadow buffer and publishes it on a
// valid/ready output register.
//
// Ports
//   clk         : single clock
//   rst         : asynchronous active-high reset
//   data_in     : asynchronous serial line, idle high
//   pkt_ready   : consumer accepts pkt_data this cycle
//   pkt_data    : payload, byte 0 at bits [7:0]
//   pkt_valid   : pkt_data holds an unconsumed packet
//   frame_err   : one-cycle pulse on a bad stop bit or a missing ETX
//   timeout_err : one-cycle pulse on an inter-byte timeout inside a packet
//   overrun     : one-cycle pulse when a completed packet is dropped
//   busy        : either FSM is away from its idle state
module uart_packet_rx #(
  parameter int          CLKS_PER_BIT  = 2604,
  parameter int          PAYLOAD_BYTES = 6,
  parameter logic [7:0]  STX           = 8'h02,
  parameter logic [7:0]  ETX           = 8'h03,
  parameter int          TIMEOUT_CLKS  = 500000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_in,
  input  logic                         pkt_ready,
  output logic [8*PAYLOAD_BYTES-1:0]   pkt_data,
  output logic                         pkt_valid,
  output logic                         frame_err,
  output logic                         timeout_err,
  output logic                         overrun,
  output logic                         busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [TW-1:0] TO_ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0] TO_ONE    = TW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [5:0]    LAST_IDX  = 6'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } bit_state_t;

  typedef enum logic [1:0] {
    P_WAIT_STX = 2'd0,
    P_PAYLOAD  = 2'd1,
    P_WAIT_ETX = 2'd2
  } pkt_state_t;

  // Line synchroniser and edge detector
  logic sync1_r;
  logic sync2_r;
  logic line_d_r;
  logic line_s;
  logic fall_s;

  // Bit FSM
  bit_state_t      bit_state_r;
  logic [CW-1:0]   bit_cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic [7:0]      rx_byte_r;
  logic            rx_done_r;
  logic            stop_err_r;

  // Packet FSM
  pkt_state_t                    pkt_state_r;
  logic [5:0]                    pay_idx_r;
  logic [8*PAYLOAD_BYTES-1:0]    shadow_r;
  logic [TW-1:0]                 to_cnt_r;
  logic [8*PAYLOAD_BYTES-1:0]    pkt_data_r;
  logic                          pkt_valid_r;
  logic                          frame_err_r;
  logic                          timeout_err_r;
  logic                          overrun_r;

  assign line_s = sync2_r;
  assign fall_s = line_d_r & ~sync2_r;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      line_d_r <= 1'b1;
    end else begin
      sync1_r  <= data_in;
      sync2_r  <= sync1_r;
      line_d_r <= sync2_r;
    end
  end

  // Bit FSM: start detection, mid-bit sampling, stop-bit check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_state_r <= B_IDLE;
      bit_cnt_r   <= CNT_ZERO;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      rx_byte_r   <= 8'h00;
      rx_done_r   <= 1'b0;
      stop_err_r  <= 1'b0;
    end else begin
      rx_done_r  <= 1'b0;
      stop_err_r <= 1'b0;
      case (bit_state_r)
        B_IDLE: begin
          // The falling edge cycle counts as clock 0 of the start bit
          if (fall_s) begin
            bit_state_r <= B_START;
            bit_cnt_r   <= CNT_ONE;
          end else begin
            bit_cnt_r   <= CNT_ZERO;
          end
        end
        B_START: begin
          if (bit_cnt_r == HALF_LAST) begin
            bit_cnt_r <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            // A high line at mid start bit is a glitch, not a start bit
            if (line_s) begin
              bit_state_r <= B_IDLE;
            end else begin
              bit_state_r <= B_DATA;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        B_DATA: begin
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_r <= CNT_ZERO;
            shift_r   <= {line_s, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              bit_state_r <= B_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        B_STOP: begin
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_r   <= CNT_ZERO;
            bit_state_r <= B_IDLE;
            if (line_s) begin
              rx_byte_r <= shift_r;
              rx_done_r <= 1'b1;
            end else begin
              stop_err_r <= 1'b1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        default: begin
          bit_state_r <= B_IDLE;
          bit_cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Packet FSM: framing, shadow buffer, output handshake, timeout and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_state_r   <= P_WAIT_STX;
      pay_idx_r     <= 6'd0;
      shadow_r      <= {(8*PAYLOAD_BYTES){1'b0}};
      to_cnt_r      <= TO_ZERO;
      pkt_data_r    <= {(8*PAYLOAD_BYTES){1'b0}};
      pkt_valid_r   <= 1'b0;
      frame_err_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      frame_err_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      overrun_r     <= 1'b0;

      if (pkt_valid_r && pkt_ready) begin
        pkt_valid_r <= 1'b0;
      end

      // Idle gap counter: runs only between bytes of an open packet
      if ((pkt_state_r == P_WAIT_STX) || rx_done_r) begin
        to_cnt_r <= TO_ZERO;
      end else if (bit_state_r == B_IDLE) begin
        to_cnt_r <= to_cnt_r + TO_ONE;
      end else begin
        to_cnt_r <= to_cnt_r;
      end

      // Priority: stop-bit error, then byte handling, then timeout
      if (stop_err_r) begin
        frame_err_r <= 1'b1;
        pkt_state_r <= P_WAIT_STX;
      end else if (rx_done_r) begin
        case (pkt_state_r)
          P_WAIT_STX: begin
            if (rx_byte_r == STX) begin
              pkt_state_r <= P_PAYLOAD;
              pay_idx_r   <= 6'd0;
            end else begin
              pkt_state_r <= P_WAIT_STX;
            end
          end
          P_PAYLOAD: begin
            for (int k = 0; k < PAYLOAD_BYTES; k++) begin
              if (pay_idx_r == 6'(k)) begin
                shadow_r[8*k +: 8] <= rx_byte_r;
              end
            end
            if (pay_idx_r == LAST_IDX) begin
              pkt_state_r <= P_WAIT_ETX;
            end else begin
              pay_idx_r <= pay_idx_r + 6'd1;
            end
          end
          P_WAIT_ETX: begin
            pkt_state_r <= P_WAIT_STX;
            if (rx_byte_r == ETX) begin
              // A same-cycle consume frees the output register for the new packet
              if (!pkt_valid_r || pkt_ready) begin
                pkt_data_r  <= shadow_r;
                pkt_valid_r <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
            end else begin
              frame_err_r <= 1'b1;
            end
          end
          default: begin
            pkt_state_r <= P_WAIT_STX;
          end
        endcase
      end else if ((pkt_state_r != P_WAIT_STX) && (bit_state_r == B_IDLE) &&
                   (to_cnt_r == TO_LAST)) begin
        timeout_err_r <= 1'b1;
        pkt_state_r   <= P_WAIT_STX;
      end else begin
        pkt_state_r <= pkt_state_r;
      end
    end
  end

  assign pkt_data    = pkt_data_r;
  assign pkt_valid   = pkt_valid_r;
  assign frame_err   = frame_err_r;
  assign timeout_err = timeout_err_r;
  assign overrun     = overrun_r;
  assign busy        = (pkt_state_r != P_WAIT_STX) || (bit_state_r != B_IDLE);

endmodule
